// File: rtl/chess_pkg.sv
// Shared chess encodings: square codes, result codes, FSM states and the start position.
// Reset and new_game both load the board through start_board().
package chess_pkg;

    localparam logic [2:0] PT_PAWN   = 3'b001;
    localparam logic [2:0] PT_KNIGHT = 3'b010;
    localparam logic [2:0] PT_BISHOP = 3'b011;
    localparam logic [2:0] PT_ROOK   = 3'b100;
    localparam logic [2:0] PT_QUEEN  = 3'b101;
    localparam logic [2:0] PT_KING   = 3'b110;

    localparam logic COL_WHITE = 1'b0;
    localparam logic COL_BLACK = 1'b1;

    localparam logic [2:0] RES_OK           = 3'b000;
    localparam logic [2:0] RES_SAME_SQ      = 3'b001;
    localparam logic [2:0] RES_EMPTY        = 3'b010;
    localparam logic [2:0] RES_WRONG_TURN   = 3'b011;
    localparam logic [2:0] RES_SELF_CAPTURE = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_RESP
    } state_t;

    // Indexed board[row][col]; row 0 is the black back rank.
    typedef logic [7:0][7:0][4:0] board_t;

    function automatic logic [4:0] sq(input logic [2:0] pt, input logic col);
        return {pt, col, 1'b1};
    endfunction

    function automatic logic [2:0] back_rank_type(input logic [2:0] col);
        logic [2:0] pt;
        case (col)
            3'd0, 3'd7: pt = PT_ROOK;
            3'd1, 3'd6: pt = PT_KNIGHT;
            3'd2, 3'd5: pt = PT_BISHOP;
            3'd3:       pt = PT_QUEEN;
            default:    pt = PT_KING;
        endcase
        return pt;
    endfunction

    function automatic board_t start_board();
        board_t b;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = sq(back_rank_type(3'(c)), COL_BLACK);
            b[1][c] = sq(PT_PAWN, COL_BLACK);
            b[6][c] = sq(PT_PAWN, COL_WHITE);
            b[7][c] = sq(back_rank_type(3'(c)), COL_WHITE);
        end
        return b;
    endfunction

endpackage

// File: rtl/move_executor.sv
// Applies one requested move to the board: validates, writes, and reports a result.
// Errors complete 2 cycles after accept, legal moves 3; one request at a time, ready only in IDLE.
module move_executor
    import chess_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         new_game,
    input  logic         move_valid,
    output logic         move_ready,
    input  logic [2:0]   from_row,
    input  logic [2:0]   from_col,
    input  logic [2:0]   to_row,
    input  logic [2:0]   to_col,
    output board_t       board,
    output logic         side_to_move,
    output logic         done,
    output logic [2:0]   result,
    output logic [4:0]   captured,
    output logic [3:0]   white_caps,
    output logic [3:0]   black_caps
);

    state_t      state, state_nxt;
    logic [2:0]  fr, fc, tr, tc;
    logic [4:0]  src, dst, moved;
    logic [2:0]  err;

    assign src = board[fr][fc];
    assign dst = board[tr][tc];

    always_comb begin
        err = RES_OK;
        if (fr == tr && fc == tc)
            err = RES_SAME_SQ;
        else if (!src[0])
            err = RES_EMPTY;
        else if (src[1] != side_to_move)
            err = RES_WRONG_TURN;
        else if (dst[0] && dst[1] == src[1])
            err = RES_SELF_CAPTURE;
    end

    // Pawns reaching the far rank always become a queen of their own colour.
    always_comb begin
        moved = src;
        if (src == sq(PT_PAWN, COL_WHITE) && tr == 3'd0)
            moved = sq(PT_QUEEN, COL_WHITE);
        else if (src == sq(PT_PAWN, COL_BLACK) && tr == 3'd7)
            moved = sq(PT_QUEEN, COL_BLACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        move_ready = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid)
                    state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = (err == RES_OK) ? S_WRITE : S_RESP;
            S_WRITE: state_nxt = S_RESP;
            S_RESP: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
        if (new_game)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board        <= start_board();
            side_to_move <= COL_WHITE;
            white_caps   <= '0;
            black_caps   <= '0;
            result       <= RES_OK;
            captured     <= '0;
            fr           <= '0;
            fc           <= '0;
            tr           <= '0;
            tc           <= '0;
        end else if (new_game) begin
            board        <= start_board();
            side_to_move <= COL_WHITE;
            white_caps   <= '0;
            black_caps   <= '0;
            result       <= RES_OK;
            captured     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (move_valid) begin
                        fr <= from_row;
                        fc <= from_col;
                        tr <= to_row;
                        tc <= to_col;
                    end
                end
                S_CHECK: begin
                    result   <= err;
                    captured <= '0;
                end
                S_WRITE: begin
                    board[tr][tc] <= moved;
                    board[fr][fc] <= '0;
                    captured      <= dst;
                    side_to_move  <= ~side_to_move;
                    if (dst[0]) begin
                        if (side_to_move == COL_WHITE) begin
                            if (white_caps != 4'd15)
                                white_caps <= white_caps + 4'd1;
                        end else begin
                            if (black_caps != 4'd15)
                                black_caps <= black_caps + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
